hcms_char_streamer: RTL

//  Upstream feeder for the HCMS serial shifter. Holds a NCHARS-glyph text buffer and looks up the built-in 5x7 font.

---
 rtl/hcms_char_streamer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hcms_char_streamer.sv
// Purpose : text-buffer + 5x7 font front end for the HCMS serial shifter; streams
//           NCHARS*5 column bytes (char0 col0 first) per frame over valid/ready.
// Latency : start in cycle N -> first col_valid in N+2; done one cycle after the
//           final column handshake (NCHARS*5+2 cycles with col_ready held high).
// Backpressure: col_valid/col_data/col_last hold while col_ready is low; start
//           is ignored while busy (not queued).
//
// Ports: clk, reset_n (async active-low); wr_en/wr_addr/wr_glyph write the back
//        buffer; start requests a frame; busy/done report frame progress;
//        col_valid/col_ready/col_data/col_last form the column stream.
// Optional build macro: HCMS_STREAMER_AUTOREFRESH_EN adds a free-running frame
//        timer (period REFRESH_DIV clocks) with a one-deep pending request.
module hcms_char_streamer #(
   parameter int NCHARS      = 4,
   parameter int REFRESH_DIV = 250000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [4:0] wr_glyph,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       col_valid,
   input  logic       col_ready,
   output logic [7:0] col_data,
   output logic       col_last
);

   localparam int CIW = (NCHARS > 1) ? $clog2(NCHARS) : 1;

   if (NCHARS < 1 || NCHARS > 8 || REFRESH_DIV < 1) begin : g_bad_params
      $error("hcms_char_streamer: NCHARS must be 1..8 and REFRESH_DIV >= 1");
   end

   // S_DONE is the one-cycle done pulse; busy stays high through it so a frame
   // spans NCHARS*5+2 busy cycles.
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [4:0]       back_buf  [NCHARS];
   logic [4:0]       front_buf [NCHARS];
   logic [CIW-1:0]   chr_idx, chr_nxt;
   logic [2:0]       col_idx, col_nxt;
   logic             start_req;
   logic             frame_go;
   logic             col_hs;

   // 5x7 font: glyph column c (0 = leftmost) as rows[6:0], bit0 = top row.
   function automatic logic [6:0] font_col(input logic [4:0] g, input logic [2:0] c);
      logic [34:0] cols;
      case (g)
         5'd0:    cols = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
         5'd1:    cols = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
         5'd2:    cols = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
         5'd3:    cols = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
         5'd4:    cols = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
         5'd5:    cols = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
         5'd6:    cols = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
         5'd7:    cols = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
         5'd8:    cols = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
         5'd9:    cols = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
         5'd10:   cols = {7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E};
         5'd11:   cols = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
         5'd12:   cols = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
         5'd13:   cols = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
         5'd14:   cols = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
         5'd15:   cols = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h01};
         5'd17:   cols = {7'h08, 7'h08, 7'h08, 7'h08, 7'h08};
         default: cols = '0;   // space and blank codes
      endcase
      case (c)
         3'd0:    return cols[34:28];
         3'd1:    return cols[27:21];
         3'd2:    return cols[20:14];
         3'd3:    return cols[13:7];
         default: return cols[6:0];
      endcase
   endfunction

`ifdef HCMS_STREAMER_AUTOREFRESH_EN
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   logic [RW-1:0] rf_cnt;
   logic          rf_tick;
   logic          rf_pend;

   assign rf_tick = (rf_cnt == RW'(REFRESH_DIV - 1));

   // A tick that lands mid-frame is remembered once and replayed in the
   // first idle cycle; any idle cycle consumes it because start_req fires.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_cnt  <= '0;
         rf_pend <= 1'b0;
      end else begin
         rf_cnt <= rf_tick ? '0 : rf_cnt + 1'b1;
         if (state == S_IDLE)
            rf_pend <= 1'b0;
         else if (rf_tick)
            rf_pend <= 1'b1;
      end
   end

   assign start_req = start | rf_tick | rf_pend;
`else
   assign start_req = start;
`endif

   assign frame_go = (state == S_IDLE) && start_req;
   assign col_hs   = col_valid && col_ready;

   // Column/glyph counters advance together; no divide by 5 needed.
   always_comb begin
      col_nxt = col_idx + 3'd1;
      chr_nxt = chr_idx;
      if (col_idx == 3'd4) begin
         col_nxt = 3'd0;
         chr_nxt = chr_idx + 1'b1;
      end
   end

   // Back buffer: host writes land here in every state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCHARS; i++) back_buf[i] <= 5'd16;
      end else begin
         for (int i = 0; i < NCHARS; i++)
            if (wr_en && wr_addr == 3'(i)) back_buf[i] <= wr_glyph;
      end
   end

   // Front buffer snapshot at frame start, with a same-cycle write merged in.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCHARS; i++) front_buf[i] <= 5'd16;
      end else if (frame_go) begin
         for (int i = 0; i < NCHARS; i++)
            front_buf[i] <= (wr_en && wr_addr == 3'(i)) ? wr_glyph : back_buf[i];
      end
   end

   // Column datapath: the presented column is registered so it stays put
   // while the shifter stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chr_idx  <= '0;
         col_idx  <= '0;
         col_data <= 8'h00;
         col_last <= 1'b0;
      end else if (state == S_LOAD) begin
         chr_idx  <= '0;
         col_idx  <= '0;
         col_data <= {1'b0, font_col(front_buf[0], 3'd0)};
         col_last <= 1'b0;
      end else if (state == S_SEND && col_hs && !col_last) begin
         chr_idx  <= chr_nxt;
         col_idx  <= col_nxt;
         col_data <= {1'b0, font_col(front_buf[chr_nxt], col_nxt)};
         col_last <= (chr_nxt == CIW'(NCHARS - 1)) && (col_nxt == 3'd4);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_req) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_SEND;
         S_SEND:  if (col_hs && col_last) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      col_valid = (state == S_SEND);
   end

endmodule
